// File: rtl/mem_access_pkg.sv
// Shared constants, encodings and payload types for the MEM pipeline stage.
// Optional feature macro: MEM_ACCESS_TIMEOUT_EN (bus timeout with error pulse).
`ifndef REG_INVALID
`define REG_INVALID 4'hF
`endif

package mem_access_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] RWE_NONE  = 2'b00;
  localparam logic [1:0] RWE_LOAD  = 2'b01;
  localparam logic [1:0] RWE_STORE = 2'b10;
  localparam logic [1:0] RWE_RSVD  = 2'b11;

  localparam logic [REG_W-1:0] REG_INVALID = `REG_INVALID;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam logic [CNT_W-1:0]  MEM_TIMEOUT_LIMIT = 4'd15;
  localparam logic [DATA_W-1:0] TIMEOUT_DATA      = 16'hFFFF;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  wreg;
  } wb_t;

  // RWE_NONE and RWE_RSVD both mean "no memory access".
  function automatic logic is_mem_op(input logic [1:0] rwe);
    return (rwe == RWE_LOAD) || (rwe == RWE_STORE);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Memory bus handshake: IDLE/ACCESS FSM, bus request registers, timeout counter.
// Optional feature macro: MEM_ACCESS_TIMEOUT_EN.
module mem_bus_ctrl
  import mem_access_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        rwe_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              ack_i,
  output logic              req_o,
  output logic              we_o,
  output logic [DATA_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              err_o,
  output logic              stall_c_o,
  output logic              start_c_o,
  output logic              done_c_o,
  output logic              tmo_c_o
);

  logic [0:0] state_q, state_d;
  logic       req_q, req_d;
  bus_req_t   bus_q, bus_d;
  logic       stall_c, start_c, done_c, tmo_c;
`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Next-state, handshake strobes and stall.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    bus_d   = bus_q;
    stall_c = 1'b0;
    start_c = 1'b0;
    done_c  = 1'b0;
    tmo_c   = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_ACCESS: begin
        if (ack_i) begin
          done_c  = 1'b1;
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (cnt_q == MEM_TIMEOUT_LIMIT) begin
          done_c  = 1'b1;
          tmo_c   = 1'b1;
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
`endif
        else begin
          stall_c = 1'b1;
`ifdef MEM_ACCESS_TIMEOUT_EN
          cnt_d   = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: begin
        // Acks seen here belong to nobody and are ignored.
        if (is_mem_op(rwe_i)) begin
          stall_c     = 1'b1;
          start_c     = 1'b1;
          req_d       = 1'b1;
          state_d     = ST_ACCESS;
          bus_d.we    = (rwe_i == RWE_STORE);
          bus_d.addr  = addr_i;
          bus_d.wdata = wdata_i;
`ifdef MEM_ACCESS_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      bus_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      bus_q   <= bus_d;
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign req_o     = req_q;
  assign we_o      = bus_q.we;
  assign addr_o    = bus_q.addr;
  assign wdata_o   = bus_q.wdata;
  assign stall_c_o = stall_c;
  assign start_c_o = start_c;
  assign done_c_o  = done_c;
  assign tmo_c_o   = tmo_c;

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: MEM/WB register and load/store data mux around mem_bus_ctrl.
// Optional feature macro: MEM_ACCESS_TIMEOUT_EN (bus timeout, see mem_bus_ctrl).
module mem_access
  import mem_access_pkg::*;
(
  input  logic              mai_clk,
  input  logic              mai_rst,
  input  logic [DATA_W-1:0] mai_instr,
  input  logic [DATA_W-1:0] mai_pc,
  input  logic [DATA_W-1:0] mai_data,
  input  logic [REG_W-1:0]  mai_wreg_addr,
  input  logic [DATA_W-1:0] mai_mem_addr,
  input  logic [DATA_W-1:0] mai_write_to_mem_data,
  input  logic [1:0]        mai_rwe,
  input  logic              mai_bus_ack,
  input  logic [DATA_W-1:0] mai_bus_rdata,
  output logic              mao_bus_req,
  output logic              mao_bus_we,
  output logic [DATA_W-1:0] mao_bus_addr,
  output logic [DATA_W-1:0] mao_bus_wdata,
  output logic              mao_stall,
  output logic [DATA_W-1:0] mao_instr,
  output logic [DATA_W-1:0] mao_pc,
  output logic [DATA_W-1:0] mao_data,
  output logic [REG_W-1:0]  mao_wreg_addr,
  output logic              mao_bus_err
);

  logic start_c, done_c, tmo_c, stall_c;
  wb_t  pend_q, pend_d;
  wb_t  wb_q, wb_d;

  mem_bus_ctrl u_bus_ctrl (
    .clk_i     (mai_clk),
    .rst_i     (mai_rst),
    .rwe_i     (mai_rwe),
    .addr_i    (mai_mem_addr),
    .wdata_i   (mai_write_to_mem_data),
    .ack_i     (mai_bus_ack),
    .req_o     (mao_bus_req),
    .we_o      (mao_bus_we),
    .addr_o    (mao_bus_addr),
    .wdata_o   (mao_bus_wdata),
    .err_o     (mao_bus_err),
    .stall_c_o (stall_c),
    .start_c_o (start_c),
    .done_c_o  (done_c),
    .tmo_c_o   (tmo_c)
  );

  // Inputs are don't-care during ACCESS, so the op is parked in pend_q on entry.
  always_comb begin
    pend_d = pend_q;
    wb_d   = wb_q;
    if (start_c) begin
      pend_d.instr = mai_instr;
      pend_d.pc    = mai_pc;
      pend_d.data  = mai_data;
      pend_d.wreg  = mai_wreg_addr;
      wb_d.wreg    = REG_INVALID;
    end else if (done_c) begin
      wb_d.instr = pend_q.instr;
      wb_d.pc    = pend_q.pc;
      wb_d.wreg  = pend_q.wreg;
      if (tmo_c) begin
        wb_d.data = TIMEOUT_DATA;
        if (!mao_bus_we) begin
          wb_d.wreg = REG_INVALID;
        end
      end else begin
        wb_d.data = mao_bus_we ? pend_q.data : mai_bus_rdata;
      end
    end else if (!stall_c) begin
      wb_d.instr = mai_instr;
      wb_d.pc    = mai_pc;
      wb_d.data  = mai_data;
      wb_d.wreg  = mai_wreg_addr;
    end
  end

  always_ff @(posedge mai_clk or posedge mai_rst) begin
    if (mai_rst) begin
      pend_q <= '0;
      wb_q   <= '{instr: '0, pc: '0, data: '0, wreg: REG_INVALID};
    end else begin
      pend_q <= pend_d;
      wb_q   <= wb_d;
    end
  end

  assign mao_stall     = stall_c;
  assign mao_instr     = wb_q.instr;
  assign mao_pc        = wb_q.pc;
  assign mao_data      = wb_q.data;
  assign mao_wreg_addr = wb_q.wreg;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: transaction-level model of each op vs. DUT.
// Build with +define+MEM_ACCESS_TIMEOUT_EN to exercise the timeout path.
module tb_mem_access;

  localparam logic [3:0] INV = mem_access_pkg::REG_INVALID;

  logic        clk, rst;
  logic [15:0] mai_instr, mai_pc, mai_data, mai_mem_addr, mai_wdata, mai_bus_rdata;
  logic [3:0]  mai_wreg_addr;
  logic [1:0]  mai_rwe;
  logic        mai_bus_ack;
  logic        mao_bus_req, mao_bus_we, mao_stall, mao_bus_err;
  logic [15:0] mao_bus_addr, mao_bus_wdata, mao_instr, mao_pc, mao_data;
  logic [3:0]  mao_wreg_addr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0]  rwe;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] data;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [3:0]  wreg;
  } op_t;

  mem_access dut (
    .mai_clk               (clk),
    .mai_rst               (rst),
    .mai_instr             (mai_instr),
    .mai_pc                (mai_pc),
    .mai_data              (mai_data),
    .mai_wreg_addr         (mai_wreg_addr),
    .mai_mem_addr          (mai_mem_addr),
    .mai_write_to_mem_data (mai_wdata),
    .mai_rwe               (mai_rwe),
    .mai_bus_ack           (mai_bus_ack),
    .mai_bus_rdata         (mai_bus_rdata),
    .mao_bus_req           (mao_bus_req),
    .mao_bus_we            (mao_bus_we),
    .mao_bus_addr          (mao_bus_addr),
    .mao_bus_wdata         (mao_bus_wdata),
    .mao_stall             (mao_stall),
    .mao_instr             (mao_instr),
    .mao_pc                (mao_pc),
    .mao_data              (mao_data),
    .mao_wreg_addr         (mao_wreg_addr),
    .mao_bus_err           (mao_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic op_t rand_op(input logic [1:0] rwe);
    op_t o;
    o.rwe   = rwe;
    o.instr = 16'($urandom);
    o.pc    = 16'($urandom);
    o.data  = 16'($urandom);
    o.addr  = 16'($urandom);
    o.wdata = 16'($urandom);
    o.rdata = 16'($urandom);
    o.wreg  = 4'($urandom_range(0, 14));
    return o;
  endfunction

  function automatic bit is_mem(input op_t op);
    return (op.rwe == 2'b01) || (op.rwe == 2'b10);
  endfunction

  // Expected MEM/WB contents once the op has retired.
  function automatic logic [51:0] exp_wb(input op_t op, input bit tmo);
    logic [15:0] d;
    logic [3:0]  w;
    d = (op.rwe == 2'b01) ? op.rdata : op.data;
    w = op.wreg;
    if (tmo) begin
      d = 16'hFFFF;
      if (op.rwe == 2'b01) w = INV;
    end
    return {op.instr, op.pc, d, w};
  endfunction

  // Presents one op, acks it ack_delay cycles after req rises (-1 = never), and
  // reports what was observed. Inputs are scrambled while the stage is busy.
  task automatic do_op(input op_t op, input int ack_delay, input bit ack_idle,
                       output int stall_cyc, output int req_cyc, output int edges,
                       output bit bus_ok, output bit req_first, output int err_cyc,
                       output bit hung);
    int k;
    bit done;
    k = 0; done = 0; stall_cyc = 0; req_cyc = 0; edges = 0;
    bus_ok = 1; req_first = 0; err_cyc = 0; hung = 0;
    while (!done) begin
      if (k == 0) begin
        mai_rwe = op.rwe; mai_instr = op.instr; mai_pc = op.pc; mai_data = op.data;
        mai_mem_addr = op.addr; mai_wdata = op.wdata; mai_wreg_addr = op.wreg;
      end else begin
        mai_rwe = 2'($urandom); mai_instr = 16'($urandom); mai_pc = 16'($urandom);
        mai_data = 16'($urandom); mai_mem_addr = 16'($urandom);
        mai_wdata = 16'($urandom); mai_wreg_addr = 4'($urandom);
      end
      mai_bus_ack   = (k == 0) ? ack_idle : (ack_delay >= 0 && k == ack_delay + 1);
      mai_bus_rdata = (mai_bus_ack && k > 0) ? op.rdata : 16'($urandom);
      @(negedge clk);
      if (k == 0) req_first = mao_bus_req;
      if (mao_bus_err) err_cyc++;
      if (mao_stall) stall_cyc++; else done = 1;
      if (mao_bus_req) begin
        req_cyc++;
        if ({mao_bus_we, mao_bus_addr, mao_bus_wdata} !== {op.rwe == 2'b10, op.addr, op.wdata})
          bus_ok = 0;
      end
      @(posedge clk); #1;
      edges++; k++;
      if (!done && k > 60) begin hung = 1; done = 1; end
    end
    mai_rwe = 2'b00;
    mai_bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mai_rwe = 2'b00; mai_bus_ack = 1'b0; mai_instr = '0; mai_pc = '0; mai_data = '0;
    mai_mem_addr = '0; mai_wdata = '0; mai_wreg_addr = '0; mai_bus_rdata = '0;
    #12;
    n_checks++;
    if ({mao_bus_req, mao_bus_we, mao_bus_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: req/we/err=%b expected 000", {mao_bus_req, mao_bus_we, mao_bus_err});
    end
    n_checks++;
    if ({mao_bus_addr, mao_bus_wdata} !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: addr/wdata=%h expected 0", {mao_bus_addr, mao_bus_wdata});
    end
    n_checks++;
    if ({mao_instr, mao_pc, mao_data, mao_wreg_addr} !== {48'h0, INV}) begin
      n_fail++; $display("FAIL reset_wb: got %h expected %h", {mao_instr, mao_pc, mao_data, mao_wreg_addr}, {48'h0, INV});
    end
    n_checks++;
    if (mao_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 0", mao_stall);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_nonmem();
    op_t op; int sc, rc, ed, ec; bit bok, rf, hg;
    op = rand_op(2'b00); op.data = 16'h1234; op.wreg = 4'd3;
    do_op(op, 0, 1'b0, sc, rc, ed, bok, rf, ec, hg);
    n_checks++;
    if ({sc, ed, rc} !== {32'd0, 32'd1, 32'd0}) begin
      n_fail++; $display("FAIL nonmem_timing: stall=%0d edges=%0d req=%0d expected 0/1/0", sc, ed, rc);
    end
    n_checks++;
    if ({mao_instr, mao_pc, mao_data, mao_wreg_addr} !== exp_wb(op, 1'b0)) begin
      n_fail++; $display("FAIL nonmem_wb: got %h expected %h", {mao_instr, mao_pc, mao_data, mao_wreg_addr}, exp_wb(op, 1'b0));
    end
  endtask

  task automatic test_load();
    op_t op; int sc, rc, ed, ec; bit bok, rf, hg;
    op = rand_op(2'b01); op.addr = 16'h8000; op.rdata = 16'hBEEF;
    do_op(op, 3, 1'b0, sc, rc, ed, bok, rf, ec, hg);
    n_checks++;
    if ({sc, rc, ed} !== {32'd4, 32'd4, 32'd5} || hg) begin
      n_fail++; $display("FAIL load_timing: stall=%0d req=%0d edges=%0d expected 4/4/5", sc, rc, ed);
    end
    n_checks++;
    if (!bok) begin
      n_fail++; $display("FAIL load_bus: bus fields wrong while req=1, expected we=0 addr=8000");
    end
    n_checks++;
    if ({mao_instr, mao_pc, mao_data, mao_wreg_addr} !== exp_wb(op, 1'b0)) begin
      n_fail++; $display("FAIL load_wb: got %h expected %h", {mao_instr, mao_pc, mao_data, mao_wreg_addr}, exp_wb(op, 1'b0));
    end
    n_checks++;
    if (mao_bus_req !== 1'b0) begin
      n_fail++; $display("FAIL load_req_after: got %b expected 0", mao_bus_req);
    end
  endtask

  task automatic test_store();
    op_t op; int sc, rc, ed, ec; bit bok, rf, hg;
    op = rand_op(2'b10); op.addr = 16'h4000; op.wdata = 16'h00AA;
    do_op(op, 0, 1'b0, sc, rc, ed, bok, rf, ec, hg);
    n_checks++;
    if ({sc, rc, ed} !== {32'd1, 32'd1, 32'd2} || hg) begin
      n_fail++; $display("FAIL store_timing: stall=%0d req=%0d edges=%0d expected 1/1/2", sc, rc, ed);
    end
    n_checks++;
    if (!bok) begin
      n_fail++; $display("FAIL store_bus: bus fields wrong while req=1, expected we=1 addr=4000 wdata=00AA");
    end
    n_checks++;
    if ({mao_instr, mao_pc, mao_data, mao_wreg_addr} !== exp_wb(op, 1'b0)) begin
      n_fail++; $display("FAIL store_wb: got %h expected %h", {mao_instr, mao_pc, mao_data, mao_wreg_addr}, exp_wb(op, 1'b0));
    end
  endtask

  // Load then store with no gap; the store also sees a stray ack while IDLE.
  task automatic test_back_to_back();
    op_t ld, st; int sc, rc, ed, ec; bit bok, rf, hg;
    ld = rand_op(2'b01); st = rand_op(2'b10);
    do_op(ld, 1, 1'b0, sc, rc, ed, bok, rf, ec, hg);
    n_checks++;
    if ({sc, rc} !== {32'd2, 32'd2} || !bok || hg) begin
      n_fail++; $display("FAIL b2b_load: stall=%0d req=%0d bus_ok=%0d expected 2/2/1", sc, rc, bok);
    end
    n_checks++;
    if ({mao_data, mao_wreg_addr} !== {ld.rdata, ld.wreg}) begin
      n_fail++; $display("FAIL b2b_load_wb: got %h expected %h", {mao_data, mao_wreg_addr}, {ld.rdata, ld.wreg});
    end
    do_op(st, 2, 1'b1, sc, rc, ed, bok, rf, ec, hg);
    n_checks++;
    if (rf !== 1'b0) begin
      n_fail++; $display("FAIL b2b_req_gap: req during IDLE cycle=%b expected 0", rf);
    end
    n_checks++;
    if ({sc, rc, ed} !== {32'd3, 32'd3, 32'd4} || !bok || hg) begin
      n_fail++; $display("FAIL b2b_store: stall=%0d req=%0d edges=%0d bus_ok=%0d expected 3/3/4/1", sc, rc, ed, bok);
    end
    n_checks++;
    if ({mao_instr, mao_pc, mao_data, mao_wreg_addr} !== exp_wb(st, 1'b0)) begin
      n_fail++; $display("FAIL b2b_store_wb: got %h expected %h", {mao_instr, mao_pc, mao_data, mao_wreg_addr}, exp_wb(st, 1'b0));
    end
  endtask

  task automatic test_reset_mid_access();
    op_t op; int sc, rc, ed, ec; bit bok, rf, hg;
    op = rand_op(2'b01);
    mai_rwe = op.rwe; mai_instr = op.instr; mai_pc = op.pc; mai_data = op.data;
    mai_mem_addr = op.addr; mai_wdata = op.wdata; mai_wreg_addr = op.wreg;
    mai_bus_ack = 1'b0;
    @(posedge clk); #1;
    mai_rwe = 2'b00;
    n_checks++;
    if (mao_bus_req !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: req=%b expected 1", mao_bus_req);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (mao_bus_req !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_req_async: req=%b expected 0 before any edge", mao_bus_req);
    end
    n_checks++;
    if ({mao_instr, mao_pc, mao_data, mao_wreg_addr} !== {48'h0, INV}) begin
      n_fail++; $display("FAIL rstmid_wb: got %h expected %h", {mao_instr, mao_pc, mao_data, mao_wreg_addr}, {48'h0, INV});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    op = rand_op(2'b00);
    do_op(op, 0, 1'b0, sc, rc, ed, bok, rf, ec, hg);
    n_checks++;
    if ({sc, ed, rc} !== {32'd0, 32'd1, 32'd0} || {mao_data, mao_wreg_addr} !== {op.data, op.wreg}) begin
      n_fail++; $display("FAIL rstmid_idle: stall=%0d edges=%0d req=%0d wb=%h expected 0/1/0 wb=%h", sc, ed, rc, {mao_data, mao_wreg_addr}, {op.data, op.wreg});
    end
  endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    op_t op; int sc, rc, ed, ec; bit bok, rf, hg;
    for (int i = 0; i < 2; i++) begin
      op = rand_op(i == 0 ? 2'b01 : 2'b10);
      do_op(op, -1, 1'b0, sc, rc, ed, bok, rf, ec, hg);
      n_checks++;
      if ({sc, rc, ed, ec} !== {32'd16, 32'd16, 32'd17, 32'd0} || hg) begin
        n_fail++; $display("FAIL timeout_timing[%0d]: stall=%0d req=%0d edges=%0d err_early=%0d expected 16/16/17/0", i, sc, rc, ed, ec);
      end
      n_checks++;
      if ({mao_bus_err, mao_bus_req} !== 2'b10) begin
        n_fail++; $display("FAIL timeout_err[%0d]: err/req=%b expected 10", i, {mao_bus_err, mao_bus_req});
      end
      n_checks++;
      if ({mao_instr, mao_pc, mao_data, mao_wreg_addr} !== exp_wb(op, 1'b1)) begin
        n_fail++; $display("FAIL timeout_wb[%0d]: got %h expected %h", i, {mao_instr, mao_pc, mao_data, mao_wreg_addr}, exp_wb(op, 1'b1));
      end
      @(posedge clk); #1;
      n_checks++;
      if (mao_bus_err !== 1'b0) begin
        n_fail++; $display("FAIL timeout_pulse[%0d]: err=%b expected 0 one cycle later", i, mao_bus_err);
      end
    end
  endtask
`else
  task automatic test_timeout();
    op_t op; int sc, rc, ed, ec; bit bok, rf, hg;
    op = rand_op(2'b01);
    do_op(op, 30, 1'b0, sc, rc, ed, bok, rf, ec, hg);
    n_checks++;
    if ({sc, rc, ec} !== {32'd31, 32'd31, 32'd0} || mao_bus_err !== 1'b0 || hg) begin
      n_fail++; $display("FAIL long_wait: stall=%0d req=%0d err_cycles=%0d err=%b expected 31/31/0/0", sc, rc, ec, mao_bus_err);
    end
    n_checks++;
    if ({mao_instr, mao_pc, mao_data, mao_wreg_addr} !== exp_wb(op, 1'b0)) begin
      n_fail++; $display("FAIL long_wait_wb: got %h expected %h", {mao_instr, mao_pc, mao_data, mao_wreg_addr}, exp_wb(op, 1'b0));
    end
  endtask
`endif

  task automatic test_random();
    op_t op; int sc, rc, ed, ec, dly, xs; bit bok, rf, hg, aidle;
    for (int i = 0; i < 40; i++) begin
      op    = rand_op(2'($urandom_range(0, 3)));
      dly   = $urandom_range(0, 6);
      aidle = 1'($urandom);
      do_op(op, dly, aidle, sc, rc, ed, bok, rf, ec, hg);
      xs = is_mem(op) ? dly + 1 : 0;
      n_checks++;
      if ({sc, rc, ed} !== {xs, xs, xs + 1} || !bok || hg || ec != 0) begin
        n_fail++; $display("FAIL rand_timing[%0d]: rwe=%b stall=%0d req=%0d edges=%0d bus_ok=%0d expected %0d/%0d/%0d/1", i, op.rwe, sc, rc, ed, bok, xs, xs, xs + 1);
      end
      n_checks++;
      if ({mao_instr, mao_pc, mao_data, mao_wreg_addr} !== exp_wb(op, 1'b0)) begin
        n_fail++; $display("FAIL rand_wb[%0d]: rwe=%b got %h expected %h", i, op.rwe, {mao_instr, mao_pc, mao_data, mao_wreg_addr}, exp_wb(op, 1'b0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load();
    test_store();
    test_back_to_back();
    test_reset_mid_access();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
